code_generator: RTL and testbench

Serial code transmitter for the lock/code path. On a start request it emits a fixed LEN-bit code pattern MSB-first, one bit per CLK, on a single serial line, framed by a VALID qualifier. It is the sending end paired with the serial code detector: its default code, 1010_1001_0011, drives that detector's output high on the final bit. A START/READY handshake paces frames, an ABORT cancels a frame, and a one-cycle DONE pulse closes each frame.

---
 rtl/code_pkg.sv | 21 ++
 rtl/code_shifter.sv | 30 +++
 rtl/code_generator.sv | 141 ++++++++++++++
 tb/tb_code_generator.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/code_pkg.sv
// Shared constants and types for the serial code path (generator and detector).
// Default code and length live here so both ends agree on the pattern.
package code_pkg;

    localparam int CODE_LEN = 12;
    localparam logic [CODE_LEN-1:0] CODE_DEFAULT = 12'hA93;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Bit index width for a code of the given length; LEN is at least 2.
    function automatic int idx_width(input int len);
        return (len < 2) ? 1 : $clog2(len);
    endfunction

    localparam int IDX_W = idx_width(CODE_LEN);

endpackage

// File: rtl/code_shifter.sv
// LEN-bit parallel-load, left-shift register with zero fill and MSB output.
// Resets to INIT so the idle register holds the code pattern.
module code_shifter #(
    parameter int             LEN  = 12,
    parameter logic [LEN-1:0] INIT = '0
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           load,
    input  logic           shift,
    input  logic [LEN-1:0] data,
    output logic           msb
);

    logic [LEN-1:0] sh_q;

    // Load has priority over shift; zeros enter at the LSB.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sh_q <= INIT;
        end else if (load) begin
            sh_q <= data;
        end else if (shift) begin
            sh_q <= {sh_q[LEN-2:0], 1'b0};
        end
    end

    assign msb = sh_q[LEN-1];

endmodule

// File: rtl/code_generator.sv
// Serial code transmitter: sends CODE MSB-first, one bit per CLK, framed by VALID,
// with START/READY pacing, synchronous ABORT and a one-cycle DONE pulse.
// Optional feature macro: CODEGEN_REPEAT_EN adds the REPEAT port (extra back-to-back copies).
//
// state | meaning
// IDLE  | READY high, waiting for START
// SEND  | VALID high, one code bit per cycle on X
// FIN   | DONE pulse, then back to IDLE
module code_generator
    import code_pkg::*;
#(
    parameter int             LEN  = CODE_LEN,
    parameter logic [LEN-1:0] CODE = LEN'(CODE_DEFAULT)
) (
    input  logic       CLK,
    input  logic       RST,
`ifdef CODEGEN_REPEAT_EN
    input  logic [3:0] REPEAT,
`endif
    input  logic       START,
    input  logic       ABORT,
    output logic       X,
    output logic       VALID,
    output logic       READY,
    output logic       DONE
);

    localparam int             IW       = idx_width(LEN);
    localparam logic [IW-1:0]  IDX_LAST = IW'(LEN - 1);
    // Bit LEN-1 goes straight to X on the load edge, so the shifter is loaded
    // one position ahead and its MSB is always the bit for the following cycle.
    localparam logic [LEN-1:0] CODE_TAIL = CODE << 1;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          load, shift, msb;
    logic          x_d, valid_d, ready_d, done_d;
`ifdef CODEGEN_REPEAT_EN
    logic [3:0]    rep_q, rep_d;
`endif

    code_shifter #(.LEN(LEN), .INIT(CODE)) u_shifter (
        .CLK   (CLK),
        .RST   (RST),
        .load  (load),
        .shift (shift),
        .data  (CODE_TAIL),
        .msb   (msb)
    );

    // Next state, index/repeat bookkeeping and next output values.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;
        shift   = 1'b0;
        x_d     = 1'b0;
        valid_d = 1'b0;
        ready_d = 1'b0;
        done_d  = 1'b0;
`ifdef CODEGEN_REPEAT_EN
        rep_d   = rep_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (START && !ABORT) begin
                    load    = 1'b1;
                    idx_d   = IDX_LAST;
                    state_d = SEND;
                    x_d     = CODE[LEN-1];
                    valid_d = 1'b1;
                    ready_d = 1'b0;
`ifdef CODEGEN_REPEAT_EN
                    rep_d   = REPEAT;
`endif
                end
            end
            SEND: begin
                if (ABORT) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    ready_d = 1'b1;
`ifdef CODEGEN_REPEAT_EN
                    rep_d   = '0;
`endif
                end else if (idx_q != '0) begin
                    shift   = 1'b1;
                    idx_d   = idx_q - 1'b1;
                    x_d     = msb;
                    valid_d = 1'b1;
`ifdef CODEGEN_REPEAT_EN
                end else if (rep_q != '0) begin
                    load    = 1'b1;
                    idx_d   = IDX_LAST;
                    rep_d   = rep_q - 1'b1;
                    x_d     = CODE[LEN-1];
                    valid_d = 1'b1;
`endif
                end else begin
                    state_d = FIN;
                    done_d  = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            idx_q   <= '0;
            X       <= 1'b0;
            VALID   <= 1'b0;
            READY   <= 1'b1;
            DONE    <= 1'b0;
`ifdef CODEGEN_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            X       <= x_d;
            VALID   <= valid_d;
            READY   <= ready_d;
            DONE    <= done_d;
`ifdef CODEGEN_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

endmodule

// File: tb/tb_code_generator.sv
// Self-checking bench for code_generator: reset, table-driven single frame,
// back-to-back, abort, async reset, optional repeat, and random stimulus
// against a queue-based reference of expected output cycles.
module tb_code_generator;
    import code_pkg::*;

    localparam int             LEN  = CODE_LEN;
    localparam logic [LEN-1:0] CODE = CODE_DEFAULT;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic [3:0] rep_in = 4'd0;
    logic       X, VALID, READY, DONE;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    code_generator dut (
        .CLK    (CLK),
        .RST    (RST),
`ifdef CODEGEN_REPEAT_EN
        .REPEAT (rep_in),
`endif
        .START  (START),
        .ABORT  (ABORT),
        .X      (X),
        .VALID  (VALID),
        .READY  (READY),
        .DONE   (DONE)
    );

    typedef struct packed {
        logic x;
        logic valid;
        logic ready;
        logic done;
    } out_t;

    typedef struct {
        logic start;
        logic abort;
        out_t exp;
    } vec_t;

    out_t cur;
    out_t q[$];

    function automatic out_t mk(input logic x, input logic v, input logic r, input logic d);
        out_t o;
        o.x = x; o.valid = v; o.ready = r; o.done = d;
        return o;
    endfunction

    function automatic out_t dut_o();
        return mk(X, VALID, READY, DONE);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur = mk(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Reference: a frame is a list of output cycles queued on an accepted START.
    // Busy whenever the shown cycle is not the ready/idle cycle.
    task automatic model_edge(input logic s, input logic a, input logic [3:0] r);
        int nrep;
`ifdef CODEGEN_REPEAT_EN
        nrep = int'(r);
`else
        nrep = 0;
`endif
        if (!cur.ready) begin
            if (a) begin
                q.delete();
                cur = mk(1'b0, 1'b0, 1'b1, 1'b0);
            end else if (q.size() != 0) begin
                cur = q.pop_front();
            end else begin
                cur = mk(1'b0, 1'b0, 1'b1, 1'b0);
            end
        end else if (s && !a) begin
            for (int rr = 0; rr <= nrep; rr++)
                for (int k = 0; k < LEN; k++)
                    q.push_back(mk(CODE[LEN-1-k], 1'b1, 1'b0, 1'b0));
            q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
            cur = q.pop_front();
        end
    endtask

    task automatic tick(input logic s, input logic a, input logic [3:0] r, input string name);
        START  = s;
        ABORT  = a;
        rep_in = r;
        model_edge(s, a, r);
        @(posedge CLK);
        #1;
        chk(name, 32'(dut_o()), 32'(cur));
    endtask

    vec_t       tbl[16];
    logic [LEN-1:0] win;
    int         n_done;
    int         n_valid;
    int         done_at;

    initial begin
        model_reset();

        // Reset held with START high: outputs stay idle, nothing starts.
        RST = 1'b0; START = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            chk("reset_hold", 32'(dut_o()), 32'(mk(1'b0, 1'b0, 1'b1, 1'b0)));
        end
        RST = 1'b1;
        tick(1'b1, 1'b0, 4'd0, "reset_release");
        chk("first_bit_after_reset", {31'd0, X}, 32'd1);
        tick(1'b0, 1'b1, 4'd0, "abort_cleanup");

        // Single frame with an ignored START during bit 3, then idle cycles.
        for (int k = 0; k < 16; k++) begin
            tbl[k].start = (k == 0 || k == 4);
            tbl[k].abort = 1'b0;
            if (k < LEN)       tbl[k].exp = mk(CODE[LEN-1-k], 1'b1, 1'b0, 1'b0);
            else if (k == LEN) tbl[k].exp = mk(1'b0, 1'b0, 1'b0, 1'b1);
            else               tbl[k].exp = mk(1'b0, 1'b0, 1'b1, 1'b0);
        end
        win = '0;
        for (int i = 0; i < 16; i++) begin
            START = tbl[i].start;
            ABORT = tbl[i].abort;
            @(posedge CLK); #1;
            chk("table", 32'(dut_o()), 32'(tbl[i].exp));
            if (VALID) win = {win[LEN-2:0], X};
            if (i == LEN - 1) chk("detector_window", 32'(win), 32'(12'hA93));
        end
        START = 1'b0;
        model_reset();

        // START held for 40 cycles: three frames, DONE three times.
        n_done = 0;
        for (int c = 0; c < 44; c++) begin
            tick(c < 40, 1'b0, 4'd0, "b2b");
            if (DONE) begin
                chk("b2b_done_cycle", 32'(c % (LEN + 2)), 32'(LEN));
                n_done++;
            end
        end
        chk("b2b_done_count", 32'(n_done), 32'd3);

        // Abort during bit 5, restart two cycles later.
        tick(1'b1, 1'b0, 4'd0, "abort_frame");
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 4'd0, "abort_frame");
        tick(1'b0, 1'b1, 4'd0, "abort");
        chk("abort_outputs", 32'(dut_o()), 32'(mk(1'b0, 1'b0, 1'b1, 1'b0)));
        tick(1'b0, 1'b0, 4'd0, "abort_gap");
        chk("abort_no_done", {31'd0, DONE}, 32'd0);
        tick(1'b1, 1'b0, 4'd0, "restart");
        chk("restart_bit0", {30'd0, X, VALID}, 32'd3);
        for (int i = 0; i < LEN + 1; i++) tick(1'b0, 1'b0, 4'd0, "restart_run");

        // ABORT in IDLE discards a simultaneous START.
        tick(1'b1, 1'b1, 4'd0, "idle_abort");
        chk("idle_abort_ready", {31'd0, READY}, 32'd1);

        // Async reset mid-frame at bit 7.
        tick(1'b1, 1'b0, 4'd0, "async_frame");
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 4'd0, "async_frame");
        #2; RST = 1'b0; #1;
        model_reset();
        chk("async_reset", 32'(dut_o()), 32'(mk(1'b0, 1'b0, 1'b1, 1'b0)));
        @(posedge CLK); #1;
        chk("async_reset_hold", 32'(dut_o()), 32'(cur));
        RST = 1'b1;

`ifdef CODEGEN_REPEAT_EN
        // REPEAT=2: 36 contiguous bits, single DONE, then READY.
        n_valid = 0; done_at = -1; n_done = 0;
        tick(1'b1, 1'b0, 4'd2, "repeat");
        for (int c = 1; c < 60; c++) begin
            if (VALID) n_valid++;
            if (DONE) begin done_at = c; n_done++; end
            if (READY) break;
            tick(1'b0, 1'b0, 4'd0, "repeat");
        end
        chk("repeat_valid_bits", 32'(n_valid), 32'(3 * LEN));
        chk("repeat_done_count", 32'(n_done), 32'd1);
        chk("repeat_done_cycle", 32'(done_at), 32'(3 * LEN + 1));
`endif

        // Random START/ABORT (and REPEAT) against the reference.
        for (int i = 0; i < 800; i++) begin
            tick(($urandom % 3) == 0, ($urandom % 12) == 0, 4'($urandom % 4), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
